// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus: default timing at 50 MHz,
// sequencer state encodings, register-select values and common command bytes.
package lcd_pkg;

  localparam int LCD_SETUP_CYCLES   = 2;
  localparam int LCD_ENABLE_CYCLES  = 12;
  localparam int LCD_HOLD_CYCLES    = 2;
  localparam int LCD_RECOVER_CYCLES = 14;
  localparam int LCD_MAX_POLLS      = 50000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ENABLE  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int BF_BIT = 7;

  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;

  // Width of a down-counter that must hold (longest phase - 1); never below 1.
  function automatic int phase_counter_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter for LCD bus phase timing; done is high while the
// count sits at zero, so a phase of N cycles is loaded with N-1.
module lcd_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_read_port.sv
// LCD read-cycle engine: runs RW=1 bus cycles for busy flag/address or RAM data,
// optionally re-polling until BF clears, and returns the byte over valid/ready.
module lcd_read_port
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES   = LCD_SETUP_CYCLES,
  parameter int ENABLE_CYCLES  = LCD_ENABLE_CYCLES,
  parameter int HOLD_CYCLES    = LCD_HOLD_CYCLES,
  parameter int RECOVER_CYCLES = LCD_RECOVER_CYCLES,
  parameter int MAX_POLLS      = LCD_MAX_POLLS
) (
  input  logic       CLOCK_50MHZ,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RS,
  input  logic       REQ_POLL,
  output logic       RESP_VALID,
  output logic [7:0] RESP_DATA,
  output logic       RESP_TIMEOUT,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_DATA_OE,
  output logic       LCD_ENABLE,
  output logic       LCD_REGISTER_SELECT,
  output logic       LCD_READ_WRITE,
  output logic [2:0] debug_state
);

  localparam int TW = phase_counter_width(SETUP_CYCLES, ENABLE_CYCLES, HOLD_CYCLES, RECOVER_CYCLES);

  logic [2:0]    state;
  logic          rs_q;
  logic          poll_q;
  logic [15:0]   poll_cnt;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_done;
  logic          poll_again;

  // Handshake: a request is taken on any edge where REQ_VALID and REQ_READY
  // are both high; RESP_VALID is a single-cycle pulse with no backpressure.
  assign poll_again = poll_q && RESP_DATA[BF_BIT] && (int'(poll_cnt) < MAX_POLLS - 1);

  always_comb begin
    timer_load  = 1'b0;
    timer_value = TW'(SETUP_CYCLES - 1);
    case (state)
      ST_IDLE:    timer_load = REQ_VALID;
      ST_SETUP: begin
        timer_load  = timer_done;
        timer_value = TW'(ENABLE_CYCLES - 1);
      end
      ST_ENABLE: begin
        timer_load  = timer_done;
        timer_value = TW'(HOLD_CYCLES - 1);
      end
      ST_HOLD: begin
        timer_load  = timer_done;
        timer_value = TW'(RECOVER_CYCLES - 1);
      end
      ST_RECOVER: timer_load = timer_done && poll_again;
      default:    timer_load = 1'b0;
    endcase
  end

  lcd_phase_timer #(.WIDTH(TW)) u_timer (
    .clk        (CLOCK_50MHZ),
    .rst_n      (RESET_N),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= ST_IDLE;
      rs_q         <= RS_CMD;
      poll_q       <= 1'b0;
      poll_cnt     <= '0;
      RESP_VALID   <= 1'b0;
      RESP_DATA    <= 8'h00;
      RESP_TIMEOUT <= 1'b0;
    end else begin
      RESP_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            state    <= ST_SETUP;
            rs_q     <= REQ_RS;
            poll_q   <= REQ_POLL & ~REQ_RS;
            poll_cnt <= '0;
          end
        end
        ST_SETUP:  if (timer_done) state <= ST_ENABLE;
        ST_ENABLE: begin
          // Data is taken on the same edge that drops E.
          if (timer_done) begin
            state     <= ST_HOLD;
            RESP_DATA <= LCD_DATA_IN;
          end
        end
        ST_HOLD:   if (timer_done) state <= ST_RECOVER;
        ST_RECOVER: begin
          if (timer_done) begin
            if (poll_again) begin
              poll_cnt <= poll_cnt + 16'd1;
              state    <= ST_SETUP;
            end else begin
              state        <= ST_IDLE;
              RESP_VALID   <= 1'b1;
              RESP_TIMEOUT <= poll_q & RESP_DATA[BF_BIT];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign REQ_READY           = (state == ST_IDLE);
  assign LCD_DATA_OE         = (state == ST_IDLE);
  assign LCD_ENABLE          = (state == ST_ENABLE);
  assign LCD_READ_WRITE      = (state == ST_SETUP) || (state == ST_ENABLE) || (state == ST_HOLD);
  assign LCD_REGISTER_SELECT = (state != ST_IDLE) && rs_q;
  assign debug_state         = state;

endmodule

// File: tb/tb_lcd_read_port.sv
// Bench for lcd_read_port: bus waveform, returned byte and poll outcome are
// predicted from the read-cycle timeline and compared every cycle.
module tb_lcd_read_port;

  localparam int S_CYC     = 2;
  localparam int EN_CYC    = 12;
  localparam int H_CYC     = 2;
  localparam int R_CYC     = 14;
  localparam int PERIOD    = S_CYC + EN_CYC + H_CYC + R_CYC;
  localparam int MAX_POLLS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rs = 1'b0;
  logic       req_poll = 1'b0;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_timeout;
  logic [7:0] lcd_data_in = 8'h00;
  logic       lcd_data_oe;
  logic       lcd_enable;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [2:0] debug_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  always #10 clk = ~clk;

  lcd_read_port #(.MAX_POLLS(MAX_POLLS)) dut (
    .CLOCK_50MHZ         (clk),
    .RESET_N             (rst_n),
    .REQ_VALID           (req_valid),
    .REQ_READY           (req_ready),
    .REQ_RS              (req_rs),
    .REQ_POLL            (req_poll),
    .RESP_VALID          (resp_valid),
    .RESP_DATA           (resp_data),
    .RESP_TIMEOUT        (resp_timeout),
    .LCD_DATA_IN         (lcd_data_in),
    .LCD_DATA_OE         (lcd_data_oe),
    .LCD_ENABLE          (lcd_enable),
    .LCD_REGISTER_SELECT (lcd_rs),
    .LCD_READ_WRITE      (lcd_rw),
    .debug_state         (debug_state)
  );

  // One request from an idle (or just-responding, when chained) port.
  // hold=1 keeps REQ_VALID high so the next call is accepted with the response.
  task automatic run_read(input logic rs, input logic poll,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input logic [7:0] junk_xor, input bit hold, input string name);
    logic [7:0] bytes [4];
    logic [5:0] got;
    logic [5:0] exp;
    logic [8:0] exp_resp;
    int reads;
    int last;
    int k;
    int ph;
    bytes = '{b0, b1, b2, b3};
    reads = 1;
    if (poll && !rs)
      while (reads < MAX_POLLS && bytes[reads-1][7]) reads++;
    exp_q.push_back({poll && !rs && bytes[reads-1][7], bytes[reads-1]});
    last = reads * PERIOD + 1;
    req_rs    = rs;
    req_poll  = poll;
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      got = {lcd_enable, lcd_rw, lcd_rs, lcd_data_oe, req_ready, resp_valid};
      ph = (c - 1) % PERIOD + 1;
      if (c < last)
        exp = {(ph > S_CYC) && (ph <= S_CYC + EN_CYC), ph <= S_CYC + EN_CYC + H_CYC, rs, 3'b000};
      else
        exp = 6'b000111;
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s pins(E,RW,RS,OE,RDY,RV) cyc=%0d got=%b exp=%b", name, c, got, exp);
      end
      if (c == last) begin
        exp_resp = exp_q.pop_front();
        n_cmp++;
        if ({resp_timeout, resp_data} !== exp_resp) begin
          n_err++;
          $display("FAIL %s resp(timeout,data) got=%h exp=%h", name, {resp_timeout, resp_data}, exp_resp);
        end
      end
      k = (c - 1) / PERIOD;
      if (k > reads - 1) k = reads - 1;
      lcd_data_in = (ph <= S_CYC + EN_CYC) ? bytes[k] : (bytes[k] ^ junk_xor);
      if (c < last) begin
        if (hold) begin
          req_valid = 1'b1;
        end else begin
          req_valid = 1'($urandom_range(0, 1));
          req_rs    = 1'($urandom_range(0, 1));
          req_poll  = 1'($urandom_range(0, 1));
        end
      end else begin
        req_valid = hold;
      end
    end
    if (!hold) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready, resp_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL %s after_resp(rdy,rv) got=%b exp=10", name, {req_ready, resp_valid});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #25;
    n_cmp++;
    if ({lcd_enable, lcd_rw, lcd_rs, lcd_data_oe, req_ready, resp_valid, resp_timeout, resp_data} !== 15'b000110_0_00000000) begin
      n_err++;
      $display("FAIL reset_state got=%b exp=000110000000000",
               {lcd_enable, lcd_rw, lcd_rs, lcd_data_oe, req_ready, resp_valid, resp_timeout, resp_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, lcd_data_oe} !== 3'b101) begin
      n_err++;
      $display("FAIL reset_release got=%b exp=101", {req_ready, resp_valid, lcd_data_oe});
    end
  endtask

  task automatic test_cmd_read();
    run_read(1'b0, 1'b0, 8'h25, 8'h00, 8'h00, 8'h00, 8'h5A, 1'b0, "cmd_read");
  endtask

  task automatic test_data_read();
    run_read(1'b1, 1'b0, 8'h44, 8'h00, 8'h00, 8'h00, 8'hBB, 1'b0, "data_read");
  endtask

  task automatic test_poll_ready();
    run_read(1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h07, 8'h81, 1'b0, "poll_ready");
  endtask

  task automatic test_poll_timeout();
    run_read(1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 1'b0, "poll_timeout");
  endtask

  task automatic test_back_to_back();
    run_read(1'b1, 1'b1, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h0F, 1'b1, "b2b_first");
    run_read(1'b1, 1'b1, 8'h9E, 8'h11, 8'h22, 8'h33, 8'hF0, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    logic [7:0] b [4];
    bit hold;
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 4; j++) begin
        b[j] = 8'($urandom);
        b[j][7] = ($urandom_range(0, 3) != 0);
      end
      hold = (i != 23) && ($urandom_range(0, 3) == 0);
      run_read(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b[0], b[1], b[2], b[3],
               8'($urandom_range(1, 255)), hold, "random");
    end
  endtask

  task automatic test_reset_mid_cycle();
    int seen;
    req_rs    = 1'b0;
    req_poll  = 1'b0;
    req_valid = 1'b1;
    lcd_data_in = 8'h3C;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    n_cmp++;
    if (lcd_enable !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid pre_E got=%b exp=1", lcd_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({lcd_enable, lcd_rw, lcd_data_oe, req_ready, resp_valid, resp_data} !== 13'b00110_00000000) begin
      n_err++;
      $display("FAIL reset_mid async got=%b exp=0011000000000",
               {lcd_enable, lcd_rw, lcd_data_oe, req_ready, resp_valid, resp_data});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 2 * PERIOD; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 || lcd_enable === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid no_resume activity=%0d rdy=%b exp activity=0 rdy=1", seen, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_read();
    test_data_read();
    test_poll_ready();
    test_poll_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
